truth_table_sequencer: RTL
==========================

// Module: truth_table_sequencer
// PURPOSE
//   Sweeps every input vector 0..2**N_IN-1 into a combinational gate-level or
//   operator block (lab-style Y = f(A,B,C[,D])). Waits for outputs to settle,
//   then compares them with an expected truth table and keeps a pass/fail record.
//   Sits between a lab top level or testbench and the combinational block under
//   check, replacing hand-written per-row stimulus sequences.
// PARAMETERS
//   N_IN   4  number of DUT inputs (MSB = A); rows = 2**N_IN; legal range 1..6
//   N_OUT  2  number of DUT outputs compared per row; legal range 1..8
//   SETTLE 1  wait cycles between applying a vector and sampling; legal range 0..15
// PORTS
//   clk        in   1                 system clock, rising edge
//   reset      in   1                 asynchronous, active-high reset
//   start      in   1                 begin a sweep; sampled only in IDLE or DONE
//   abort      in   1                 stop the sweep; returns to IDLE
//   exp_table  in   N_OUT*2**N_IN     expected outputs; row r = bits [r*N_OUT +: N_OUT]; static during a sweep
//   dut_out    in   N_OUT             outputs of the combinational block
//   dut_in     out  N_IN              vector driven to the block
//   busy       out  1                 high in APPLY/WAIT/CHECK
//   row_valid  out  1                 1-cycle pulse in CHECK; row_vec/row_ok valid with it
//   row_vec    out  N_IN              row being checked (equals dut_in)
//   row_ok     out  1                 dut_out == expected row during the row_valid cycle
//   done       out  1                 high in DONE; held until start, abort or reset
//   pass       out  1                 valid when done: err_count == 0
//   err_count  out  N_IN+1            mismatching rows this sweep; saturates at 2**N_IN
//   first_fail out  N_IN              lowest failing row; valid when fail_seen
//   fail_seen  out  1                 at least one mismatch this sweep
// BEHAVIOUR
// - Reset (async, any state): state=IDLE; every output 0; internal counters 0.
// - FSM states IDLE, APPLY, WAIT, CHECK, DONE. All outputs are registered.
// - IDLE:
//   - on start: vec=0, err_count=0, fail_seen=0, first_fail=0 -> APPLY.
// - APPLY (1 cycle):
//   - dut_in=vec; wait counter loaded with SETTLE.
//   - -> WAIT if SETTLE>0, else -> CHECK.
// - WAIT:
//   - counter decrements each cycle; -> CHECK on the cycle it reaches 0.
//   - This gives exactly SETTLE cycles in WAIT.
// - CHECK (1 cycle):
//   - row_valid=1; row_vec=vec; row_ok=(dut_out == exp row vec).
//   - On mismatch: err_count+1 (saturating). If fail_seen was 0, first_fail=vec
//     and fail_seen=1.
//   - vec == 2**N_IN-1 -> DONE; otherwise vec+1 -> APPLY.
//   - vec never wraps.
// - Per-row timing: SETTLE+2 cycles. Full sweep: 2**N_IN*(SETTLE+2) cycles.
//   Count from the first APPLY cycle to DONE entry.
// - DONE:
//   - done=1; pass=(err_count==0); busy=0.
//   - Results hold until the next start. start in DONE clears results, as in IDLE.
// - start while busy: ignored, with no restart and no side effects.
// - abort (any non-IDLE state): -> IDLE next cycle.
//   - busy/done/row_valid drop to 0.
//   - err_count, fail_seen and first_fail keep their last values; pass=0.
//   - dut_in holds its last value.
// - abort and start in the same cycle: abort wins.
// - Reset mid-sweep behaves like power-up; no partial result is retained.
// - Output comparison covers all N_OUT bits. X/Z on dut_out counts as a mismatch
//   in simulation, via !== semantics.
// TESTING
// 1. N_IN=3, N_OUT=1, SETTLE=1; DUT matches the table; start pulse.
//    -> dut_in steps 0..7; 8 row_valid pulses, all row_ok=1.
//    -> done 24 cycles after the first APPLY; pass=1, err_count=0.
// 2. Same setup; exp_table row 5 inverted.
//    -> row_ok=0 only at row_vec=5; err_count=1, first_fail=5, fail_seen=1, pass=0.
// 3. N_IN=4, N_OUT=2; exp_table all-zero, DUT drives 2'b11.
//    -> err_count=16 (no overflow), first_fail=0, pass=0.
// 4. Assert abort during WAIT of row 3.
//    -> IDLE next cycle; busy=0, done=0, dut_in=3.
//    -> A new start re-sweeps from 0 with cleared counters.
// 5. Pulse start at row 2, then abort and start together.
//    -> Mid-sweep start ignored; combined abort+start ends in IDLE.
// 6. SETTLE=0: each row takes 2 cycles (16 for N_IN=3).
//    Assert reset mid-CHECK -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/truth_table_sequencer.sv
// rtl/truth_table_sequencer.sv - sweeps all input vectors through a combinational block and checks each row against a truth table
module truth_table_sequencer #(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 2,
    parameter int SETTLE = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
    input  logic [N_OUT*(2**N_IN)-1:0]  exp_table,
    input  logic [N_OUT-1:0]            dut_out,
    output logic [N_IN-1:0]             dut_in,
    output logic                        busy,
    output logic                        row_valid,
    output logic [N_IN-1:0]             row_vec,
    output logic                        row_ok,
    output logic                        done,
    output logic                        pass,
    output logic [N_IN:0]               err_count,
    output logic [N_IN-1:0]             first_fail,
    output logic                        fail_seen
);

    typedef enum logic [2:0] {S_IDLE, S_APPLY, S_WAIT, S_CHECK, S_DONE} state_t;

    localparam logic [N_IN-1:0] VEC_MAX = {N_IN{1'b1}};
    localparam logic [N_IN:0]   ERR_MAX = {1'b1, {N_IN{1'b0}}};

    state_t          state, state_next;
    logic [N_IN-1:0] vec;
    logic [3:0]      cnt;
    logic [N_OUT-1:0] exp_row;
    logic            mismatch;

    always_comb begin
        state_next = state;
        exp_row    = exp_table[vec*N_OUT +: N_OUT];
        // X/Z on the block's outputs must count as a failing row
        mismatch   = (dut_out !== exp_row);
        case (state)
            S_IDLE:  if (start && !abort) state_next = S_APPLY;
            S_APPLY: begin
                if (abort)           state_next = S_IDLE;
                else if (SETTLE > 0) state_next = S_WAIT;
                else                 state_next = S_CHECK;
            end
            S_WAIT: begin
                if (abort)           state_next = S_IDLE;
                else if (cnt == 4'd1) state_next = S_CHECK;
            end
            S_CHECK: begin
                if (abort)               state_next = S_IDLE;
                else if (vec == VEC_MAX) state_next = S_DONE;
                else                     state_next = S_APPLY;
            end
            S_DONE: begin
                if (abort)      state_next = S_IDLE;
                else if (start) state_next = S_APPLY;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            vec        <= '0;
            cnt        <= '0;
            dut_in     <= '0;
            busy       <= 1'b0;
            row_valid  <= 1'b0;
            row_vec    <= '0;
            row_ok     <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
            fail_seen  <= 1'b0;
        end else begin
            state     <= state_next;
            busy      <= (state_next == S_APPLY) || (state_next == S_WAIT) || (state_next == S_CHECK);
            row_valid <= (state_next == S_CHECK);
            done      <= (state_next == S_DONE);
            pass      <= (state_next == S_DONE) && (err_count == '0);
            row_ok    <= 1'b0;
            case (state_next)
                S_APPLY: begin
                    cnt <= 4'(SETTLE);
                    if (state == S_CHECK) begin
                        vec    <= vec + 1'b1;
                        dut_in <= vec + 1'b1;
                    end else begin
                        vec        <= '0;
                        dut_in     <= '0;
                        err_count  <= '0;
                        fail_seen  <= 1'b0;
                        first_fail <= '0;
                    end
                end
                S_WAIT: begin
                    if (state == S_WAIT) cnt <= cnt - 4'd1;
                end
                S_CHECK: begin
                    row_vec <= vec;
                    row_ok  <= !mismatch;
                    if (mismatch) begin
                        if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
                        if (!fail_seen) begin
                            first_fail <= vec;
                            fail_seen  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
